mem_bus_arbiter: RTL and testbench

Shares the single main-memory block port between the instruction cache and the data cache on misses and write-backs. Sits between the two cache controllers and the main memory model, below the fetch and memory-access units. One transaction is in flight at a time. Command and data are latched at grant, and a one-cycle acknowledge returns the read block to the owning cache.

---
 rtl/mem_bus_arbiter_if.sv | 46 ++++
 rtl/mem_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two cache controllers, the block arbiter and main memory.
// The master view belongs to the arbiter; the slave view is the caches plus memory.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W  = 28,
    parameter int BLOCK_W = 128
);
    // icache side
    logic               i_read;
    logic [ADDR_W-1:0]  i_address;
    logic [BLOCK_W-1:0] i_readdata;
    logic               i_ack;
    // dcache side
    logic               d_read;
    logic               d_write;
    logic [ADDR_W-1:0]  d_address;
    logic [BLOCK_W-1:0] d_writedata;
    logic [BLOCK_W-1:0] d_readdata;
    logic               d_ack;
    // memory side
    logic               mem_read;
    logic               mem_write;
    logic [ADDR_W-1:0]  mem_address;
    logic [BLOCK_W-1:0] mem_writedata;
    logic [BLOCK_W-1:0] mem_readdata;
    logic               mem_busywait;
    // status
    logic               grant_d;

    modport master (
        input  i_read, i_address,
        input  d_read, d_write, d_address, d_writedata,
        input  mem_readdata, mem_busywait,
        output i_readdata, i_ack, d_readdata, d_ack,
        output mem_read, mem_write, mem_address, mem_writedata,
        output grant_d
    );

    modport slave (
        output i_read, i_address,
        output d_read, d_write, d_address, d_writedata,
        output mem_readdata, mem_busywait,
        input  i_readdata, i_ack, d_readdata, d_ack,
        input  mem_read, mem_write, mem_address, mem_writedata,
        input  grant_d
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single main-memory block port between icache and dcache.
// One transaction in flight; round-robin on ties; all outputs registered.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int BLOCK_W = 128
) (
    input logic                clk,
    input logic                reset,
    mem_bus_arbiter_if.master  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;   // 0 = icache, 1 = dcache
    logic               grant_d_q, grant_d_d;         // also serves as the owner flag
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  mem_address_q, mem_address_d;
    logic [BLOCK_W-1:0] mem_writedata_q, mem_writedata_d;
    logic               i_ack_q, i_ack_d;
    logic               d_ack_q, d_ack_d;
    logic [BLOCK_W-1:0] i_readdata_q, i_readdata_d;
    logic [BLOCK_W-1:0] d_readdata_q, d_readdata_d;

    logic i_req;
    logic d_req;
    logic pick_d;
    logic d_is_write;

    // Request decode: on a tie the side not granted last wins
    always_comb begin
        i_req      = bus.i_read;
        d_req      = bus.d_read | bus.d_write;
        pick_d     = d_req & (~i_req | ~last_grant_q);
        d_is_write = pick_d & bus.d_write;
    end

    // State and output registers; reset aborts any transaction in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            last_grant_q    <= 1'b0;
            grant_d_q       <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            i_ack_q         <= 1'b0;
            d_ack_q         <= 1'b0;
            i_readdata_q    <= '0;
            d_readdata_q    <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            grant_d_q       <= grant_d_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            i_ack_q         <= i_ack_d;
            d_ack_q         <= d_ack_d;
            i_readdata_q    <= i_readdata_d;
            d_readdata_q    <= d_readdata_d;
        end
    end

    // Next-state sequencing: IDLE -> ISSUE -> WAIT (until memory ready) -> DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_req || d_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (!bus.mem_busywait) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values: latch at grant, complete in WAIT, release in DONE
    always_comb begin
        last_grant_d    = last_grant_q;
        grant_d_d       = grant_d_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        i_ack_d         = 1'b0;
        d_ack_d         = 1'b0;
        i_readdata_d    = i_readdata_q;
        d_readdata_d    = d_readdata_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_d_d     = pick_d;
                    mem_address_d = pick_d ? bus.d_address : bus.i_address;
                    mem_write_d   = d_is_write;
                    mem_read_d    = ~d_is_write;
                    if (d_is_write) mem_writedata_d = bus.d_writedata;
                end
            end
            WAIT: begin
                if (!bus.mem_busywait) begin
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    last_grant_d = grant_d_q;
                    if (grant_d_q) begin
                        d_ack_d = 1'b1;
                        if (mem_read_q) d_readdata_d = bus.mem_readdata;
                    end else begin
                        i_ack_d      = 1'b1;
                        i_readdata_d = bus.mem_readdata;
                    end
                end
            end
            DONE:    grant_d_d = 1'b0;
            default: ;
        endcase
    end

    assign bus.grant_d       = grant_d_q;
    assign bus.mem_read      = mem_read_q;
    assign bus.mem_write     = mem_write_q;
    assign bus.mem_address   = mem_address_q;
    assign bus.mem_writedata = mem_writedata_q;
    assign bus.i_ack         = i_ack_q;
    assign bus.d_ack         = d_ack_q;
    assign bus.i_readdata    = i_readdata_q;
    assign bus.d_readdata    = d_readdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with a 16-entry block memory.
module tb_mem_bus_arbiter;

    localparam int AW = 28;
    localparam int BW = 128;

    localparam logic [BW-1:0] V0  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [BW-1:0] V1  = 128'hA1A1A1A1_00000001_A1A1A1A1_00000001;
    localparam logic [BW-1:0] V2  = 128'hB2B2B2B2_00000002_B2B2B2B2_00000002;
    localparam logic [BW-1:0] V3  = 128'hC3C3C3C3_00000003_C3C3C3C3_00000003;
    localparam logic [BW-1:0] V4  = 128'hD4D4D4D4_00000004_D4D4D4D4_00000004;
    localparam logic [BW-1:0] V5  = 128'hE5E5E5E5_00000005_E5E5E5E5_00000005;
    localparam logic [BW-1:0] VWB = 128'h11112222_33334444_55556666_77778888;

    logic clk;
    logic reset;
    logic [BW-1:0] memarr [16];
    int total;
    int bad;

    mem_bus_arbiter_if #(.ADDR_W(AW), .BLOCK_W(BW)) bus ();

    mem_bus_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.mem_readdata = memarr[bus.mem_address[3:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock and sample 1 time unit after the edge; check invariants
    task automatic step();
        @(posedge clk);
        #1;
        total++;
        if (bus.i_ack && bus.d_ack) begin
            bad++;
            $display("FAIL ack_onehot: i_ack=%b d_ack=%b required not both 1", bus.i_ack, bus.d_ack);
        end
        total++;
        if (bus.mem_read && bus.mem_write) begin
            bad++;
            $display("FAIL cmd_onehot: mem_read=%b mem_write=%b required not both 1", bus.mem_read, bus.mem_write);
        end
    endtask

    task automatic wait_ack(input int limit, output int n, output logic gi, output logic gd);
        n = 0; gi = 1'b0; gd = 1'b0;
        for (int k = 0; k < limit; k++) begin
            step();
            n++;
            if (bus.i_ack || bus.d_ack) begin
                gi = bus.i_ack;
                gd = bus.d_ack;
                break;
            end
        end
        if (!gi && !gd) begin
            total++; bad++;
            $display("FAIL ack_timeout: no ack after %0d cycles, required an ack", limit);
        end
    endtask

    task automatic test_reset();
        int n; logic gi, gd;
        reset = 1'b0;
        bus.i_read = 1'b1; bus.i_address = 28'h5;
        step(); step();
        total++;
        if ({bus.mem_read, bus.mem_write, bus.i_ack, bus.d_ack, bus.grant_d} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: rd/wr/iack/dack/gd=%b required 00000",
                     {bus.mem_read, bus.mem_write, bus.i_ack, bus.d_ack, bus.grant_d});
        end
        total++;
        if (bus.mem_address !== '0 || bus.mem_writedata !== '0 || bus.i_readdata !== '0 || bus.d_readdata !== '0) begin
            bad++;
            $display("FAIL reset_data: addr=%h wdata=%h ird=%h drd=%h required all 0",
                     bus.mem_address, bus.mem_writedata, bus.i_readdata, bus.d_readdata);
        end
        reset = 1'b1;
        step();
        total++;
        if (bus.mem_read !== 1'b1 || bus.mem_address !== 28'h5) begin
            bad++;
            $display("FAIL reset_release: mem_read=%b addr=%h required 1 / 5", bus.mem_read, bus.mem_address);
        end
        wait_ack(10, n, gi, gd);
        total++;
        if (!gi || n != 2 || bus.i_readdata !== V5) begin
            bad++;
            $display("FAIL reset_first_read: iack=%b n=%0d data=%h required 1 / 2 / %h", gi, n, bus.i_readdata, V5);
        end
        bus.i_read = 1'b0;
        step();
    endtask

    task automatic test_single_icache();
        int n; logic gi, gd;
        bus.i_read = 1'b1; bus.i_address = 28'h0000010;
        wait_ack(10, n, gi, gd);
        total++;
        if (n != 3 || !gi || gd) begin
            bad++;
            $display("FAIL single_latency: n=%0d iack=%b dack=%b required 3 / 1 / 0", n, gi, gd);
        end
        total++;
        if (bus.i_readdata !== V0) begin
            bad++;
            $display("FAIL single_data: got %h required %h", bus.i_readdata, V0);
        end
        bus.i_read = 1'b0;
        step();
        total++;
        if (bus.i_ack !== 1'b0 || bus.i_readdata !== V0) begin
            bad++;
            $display("FAIL single_pulse_hold: iack=%b data=%h required 0 / %h", bus.i_ack, bus.i_readdata, V0);
        end
    endtask

    task automatic test_tie();
        int n; logic gi, gd;
        reset = 1'b0; #1; reset = 1'b1;
        bus.i_read = 1'b1; bus.i_address = 28'h1;
        bus.d_read = 1'b1; bus.d_address = 28'h2;
        step();
        total++;
        if (bus.grant_d !== 1'b1 || bus.mem_address !== 28'h2) begin
            bad++;
            $display("FAIL tie_grant: grant_d=%b addr=%h required 1 / 2", bus.grant_d, bus.mem_address);
        end
        wait_ack(10, n, gi, gd);
        total++;
        if (!gd || n != 2 || bus.d_readdata !== V2) begin
            bad++;
            $display("FAIL tie_first: dack=%b n=%0d data=%h required 1 / 2 / %h", gd, n, bus.d_readdata, V2);
        end
        bus.d_read = 1'b0;
        wait_ack(10, n, gi, gd);
        total++;
        if (!gi || n != 4 || bus.i_readdata !== V1) begin
            bad++;
            $display("FAIL tie_second: iack=%b n=%0d data=%h required 1 / 4 / %h", gi, n, bus.i_readdata, V1);
        end
        bus.i_read = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        int n; logic gi, gd; logic exp_d;
        bus.i_read = 1'b1; bus.i_address = 28'h1;
        bus.d_read = 1'b1; bus.d_address = 28'h2;
        for (int k = 0; k < 6; k++) begin
            exp_d = (k % 2 == 0);
            wait_ack(10, n, gi, gd);
            total++;
            if (gd !== exp_d || gi !== !exp_d || n != 3) begin
                bad++;
                $display("FAIL rr_order_%0d: dack=%b iack=%b n=%0d required dack=%b n=3", k, gd, gi, n, exp_d);
            end
            if (gd) bus.d_read = 1'b0;
            if (gi) bus.i_read = 1'b0;
            step();
            if (k < 5) begin
                if (gd) bus.d_read = 1'b1;
                if (gi) bus.i_read = 1'b1;
            end
        end
        total++;
        if (bus.i_readdata !== V1 || bus.d_readdata !== V2) begin
            bad++;
            $display("FAIL rr_data: ird=%h drd=%h required %h / %h", bus.i_readdata, bus.d_readdata, V1, V2);
        end
        bus.i_read = 1'b0; bus.d_read = 1'b0;
    endtask

    task automatic test_writeback();
        int n; logic gi, gd;
        bus.d_write = 1'b1; bus.d_address = 28'h7; bus.d_writedata = VWB;
        step();
        total++;
        if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_writedata !== VWB
            || bus.mem_address !== 28'h7 || bus.grant_d !== 1'b1) begin
            bad++;
            $display("FAIL wb_issue: wr=%b rd=%b wdata=%h addr=%h gd=%b required 1 0 %h 7 1",
                     bus.mem_write, bus.mem_read, bus.mem_writedata, bus.mem_address, bus.grant_d, VWB);
        end
        memarr[bus.mem_address[3:0]] = bus.mem_writedata;
        wait_ack(10, n, gi, gd);
        total++;
        if (!gd || n != 2 || bus.mem_write !== 1'b0 || bus.d_readdata !== V2) begin
            bad++;
            $display("FAIL wb_ack: dack=%b n=%0d wr=%b drd=%h required 1 2 0 %h", gd, n, bus.mem_write, bus.d_readdata, V2);
        end
        bus.d_write = 1'b0;
        step();
        total++;
        if (bus.grant_d !== 1'b0) begin
            bad++;
            $display("FAIL wb_grant_release: grant_d=%b required 0", bus.grant_d);
        end
        bus.d_read = 1'b1;
        wait_ack(10, n, gi, gd);
        total++;
        if (!gd || n != 3 || bus.d_readdata !== VWB) begin
            bad++;
            $display("FAIL wb_fill: dack=%b n=%0d data=%h required 1 3 %h", gd, n, bus.d_readdata, VWB);
        end
        bus.d_read = 1'b0;
        step();
    endtask

    task automatic test_busywait();
        logic early;
        early = 1'b0;
        bus.i_read = 1'b1; bus.i_address = 28'h3;
        bus.mem_busywait = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            if (bus.i_ack || bus.d_ack) early = 1'b1;
        end
        total++;
        if (early || bus.mem_read !== 1'b1) begin
            bad++;
            $display("FAIL bw_hold: early_ack=%b mem_read=%b required 0 / 1", early, bus.mem_read);
        end
        bus.mem_busywait = 1'b0;
        step();
        total++;
        if (bus.i_ack !== 1'b1 || bus.i_readdata !== V3) begin
            bad++;
            $display("FAIL bw_ack: iack=%b data=%h required 1 / %h", bus.i_ack, bus.i_readdata, V3);
        end
        bus.i_read = 1'b0;
        step();
    endtask

    task automatic test_withdraw();
        int n; logic gi, gd; int acks;
        bus.i_read = 1'b1; bus.i_address = 28'h4;
        step(); step();
        bus.i_read = 1'b0;
        wait_ack(10, n, gi, gd);
        total++;
        if (!gi || n != 1 || bus.i_readdata !== V4) begin
            bad++;
            $display("FAIL withdraw_ack: iack=%b n=%0d data=%h required 1 1 %h", gi, n, bus.i_readdata, V4);
        end
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.i_ack || bus.d_ack || bus.mem_read) acks++;
        end
        total++;
        if (acks != 0) begin
            bad++;
            $display("FAIL withdraw_once: extra activity cycles=%0d required 0", acks);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        bus.i_read = 1'b1; bus.i_address = 28'h5;
        bus.mem_busywait = 1'b1;
        step(); step();
        total++;
        if (bus.mem_read !== 1'b1) begin
            bad++;
            $display("FAIL mid_wait: mem_read=%b required 1", bus.mem_read);
        end
        reset = 1'b0;
        #1;
        total++;
        if (bus.mem_read !== 1'b0 || bus.i_ack !== 1'b0 || bus.i_readdata !== '0) begin
            bad++;
            $display("FAIL mid_reset: mem_read=%b iack=%b ird=%h required 0 0 0", bus.mem_read, bus.i_ack, bus.i_readdata);
        end
        bus.i_read = 1'b0;
        bus.mem_busywait = 1'b0;
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (bus.i_ack || bus.d_ack || bus.mem_read) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_no_ack: activity cycles=%0d required 0", seen);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b0;
        bus.i_read = 1'b0; bus.i_address = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_writedata = '0;
        bus.mem_busywait = 1'b0;
        for (int k = 0; k < 16; k++) memarr[k] = '0;
        memarr[0] = V0; memarr[1] = V1; memarr[2] = V2;
        memarr[3] = V3; memarr[4] = V4; memarr[5] = V5;

        test_reset();
        test_single_icache();
        test_tie();
        test_round_robin();
        test_writeback();
        test_busywait();
        test_withdraw();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
